// File: rtl/pipeline_bus_pkg.sv
// Package for the MEM-stage bus arbiter.
// Holds the arbiter state encoding and the system address map constants.
// The address-guard constant DMEM_LIMIT is only consumed when the design is
// built with ARB_ADDR_GUARD_EN defined.
package pipeline_bus_pkg;

    // SHARE: CPU has priority, DMA fills idle cycles.
    // FORCE: one-cycle DMA slot with the pipeline stalled.
    typedef enum logic [0:0] {
        SHARE = 1'b0,
        FORCE = 1'b1
    } arb_state_e;

    // Address map: data memory below DMEM_LIMIT, peripherals below PERIPH_LIMIT.
    localparam logic [31:0] DMEM_LIMIT   = 32'h0000_03ff;
    localparam logic [31:0] PERIPH_LIMIT = 32'h4000_0018;

endpackage

// File: rtl/pipeline_mem_bus_arbiter_if.sv
// Bundle of the CPU-side, DMA-side and shared-bus signals of the arbiter.
// Modports:
//   master : view of the arbiter itself (drives grants, bus strobes, read data)
//   slave  : view of the surrounding system (CPU MEM stage, DMA engine, slaves)
interface pipeline_mem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_rd;
    logic          cpu_wr;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;

    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_wr;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;
    logic          dma_err;

    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_rd;
    logic          bus_wr;
    logic [DW-1:0] bus_rdata;
    logic          bus_owner;

    modport master (
        input  cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_addr, dma_wdata, dma_wr,
        output dma_ack, dma_rdata, dma_err,
        output bus_addr, bus_wdata, bus_rd, bus_wr, bus_owner,
        input  bus_rdata
    );

    modport slave (
        output cpu_addr, cpu_wdata, cpu_rd, cpu_wr,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_addr, dma_wdata, dma_wr,
        input  dma_ack, dma_rdata, dma_err,
        input  bus_addr, bus_wdata, bus_rd, bus_wr, bus_owner,
        output bus_rdata
    );
endinterface

// File: rtl/pipeline_arb_starve_cnt.sv
// Saturating count of consecutive cycles the DMA request was blocked by the CPU.
// Ports:
//   clk   in  clock, rising edge
//   reset in  asynchronous, active-low
//   inc   in  DMA blocked this cycle
//   clr   in  restart the count (takes precedence over inc)
//   hit   out count has reached MAX_WAIT-1 (this blocked cycle is the last one)
module pipeline_arb_starve_cnt #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Next count: clear wins, increment saturates at all ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {WAIT_W{1'b0}};
        end else if (inc && (count_q != {WAIT_W{1'b1}})) begin
            count_d = count_q + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= {WAIT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = (count_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/pipeline_mem_bus_arbiter.sv
// MEM-stage data bus arbiter between the CPU MEM stage (priority) and a UART-RX
// DMA engine. After MAX_WAIT consecutive blocked DMA cycles a one-cycle FORCE
// slot grants the DMA and stalls the pipeline. All grant/strobe outputs are
// combinational from the current state and inputs; read data is passed through.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-low; forces all strobes/grants to 0
//   bif    master modport of pipeline_mem_bus_arbiter_if (CPU, DMA, bus signals)
// Optional feature: define ARB_ADDR_GUARD_EN to reject DMA accesses at or above
// DMEM_LIMIT (acked with dma_err, no bus strobe).
module pipeline_mem_bus_arbiter
    import pipeline_bus_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input logic                         clk,
    input logic                         reset,
    pipeline_mem_bus_arbiter_if.master  bif
);
    arb_state_e    state_q;
    arb_state_e    state_d;

    logic          cpu_acc_s;
    logic          dma_bad_s;
    logic          cnt_inc_s;
    logic          cnt_clr_s;
    logic          cnt_hit_s;

    logic [AW-1:0] bus_addr_s;
    logic [DW-1:0] bus_wdata_s;
    logic          bus_rd_s;
    logic          bus_wr_s;
    logic          bus_owner_s;
    logic          cpu_stall_s;
    logic          dma_ack_s;
    logic          dma_err_s;

    pipeline_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc_s),
        .clr   (cnt_clr_s),
        .hit   (cnt_hit_s)
    );

    // Address guard: DMA may only touch data memory when the guard is built in.
    always_comb begin
`ifdef ARB_ADDR_GUARD_EN
        dma_bad_s = (bif.dma_addr >= AW'(DMEM_LIMIT));
`else
        dma_bad_s = 1'b0;
`endif
    end

    // Next-state and grant decode.
    always_comb begin
        state_d     = state_q;
        cpu_acc_s   = bif.cpu_rd | bif.cpu_wr;
        bus_addr_s  = bif.cpu_addr;
        bus_wdata_s = bif.cpu_wdata;
        bus_rd_s    = 1'b0;
        bus_wr_s    = 1'b0;
        bus_owner_s = 1'b0;
        cpu_stall_s = 1'b0;
        dma_ack_s   = 1'b0;
        dma_err_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        cnt_clr_s   = 1'b0;
        case (state_q)
            SHARE: begin
                if (cpu_acc_s) begin
                    bus_rd_s = bif.cpu_rd;
                    bus_wr_s = bif.cpu_wr;
                    if (bif.dma_req) begin
                        cnt_inc_s = 1'b1;
                        if (cnt_hit_s) begin
                            state_d = FORCE;
                        end else begin
                            state_d = SHARE;
                        end
                    end else begin
                        cnt_clr_s = 1'b1;
                    end
                end else if (bif.dma_req) begin
                    // Zero-latency grant into an idle CPU cycle.
                    bus_addr_s  = bif.dma_addr;
                    bus_wdata_s = bif.dma_wdata;
                    bus_rd_s    = ~dma_bad_s & ~bif.dma_wr;
                    bus_wr_s    = ~dma_bad_s &  bif.dma_wr;
                    bus_owner_s = 1'b1;
                    dma_ack_s   = 1'b1;
                    dma_err_s   = dma_bad_s;
                    cnt_clr_s   = 1'b1;
                end else begin
                    cnt_clr_s = 1'b1;
                end
            end
            FORCE: begin
                // Pipeline frozen; any CPU store this cycle is dropped and replayed.
                cpu_stall_s = 1'b1;
                cnt_clr_s   = 1'b1;
                state_d     = SHARE;
                if (bif.dma_req) begin
                    bus_addr_s  = bif.dma_addr;
                    bus_wdata_s = bif.dma_wdata;
                    bus_rd_s    = ~dma_bad_s & ~bif.dma_wr;
                    bus_wr_s    = ~dma_bad_s &  bif.dma_wr;
                    bus_owner_s = 1'b1;
                    dma_ack_s   = 1'b1;
                    dma_err_s   = dma_bad_s;
                end else begin
                    bus_owner_s = 1'b0;
                end
            end
            default: begin
                state_d   = SHARE;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SHARE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes and grants are held low while reset is asserted, even mid-FORCE.
    assign bif.bus_addr  = bus_addr_s;
    assign bif.bus_wdata = bus_wdata_s;
    assign bif.bus_rd    = reset & bus_rd_s;
    assign bif.bus_wr    = reset & bus_wr_s;
    assign bif.bus_owner = reset & bus_owner_s;
    assign bif.cpu_stall = reset & cpu_stall_s;
    assign bif.dma_ack   = reset & dma_ack_s;
    assign bif.dma_err   = reset & dma_err_s;
    assign bif.cpu_rdata = bif.bus_rdata;
    assign bif.dma_rdata = bif.bus_rdata;

endmodule

// File: tb/tb_pipeline_mem_bus_arbiter.sv
module tb_pipeline_mem_bus_arbiter;
    localparam int MAX_WAIT = 4;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    bit   guard_on;

    pipeline_mem_bus_arbiter_if #(.AW(32), .DW(32)) bif ();

    pipeline_mem_bus_arbiter #(
        .AW(32), .DW(32), .MAX_WAIT(MAX_WAIT), .WAIT_W(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // The model counts the current run of consecutive blocked DMA cycles; once
    // the run reaches MAX_WAIT the following cycle is a forced DMA slot.
    int   m_blocked;
    bit   m_force;
    logic e_rd, e_wr, e_own, e_stall, e_ack, e_err;
    logic [31:0] e_addr, e_wdata;
    bit   m_bad;

    always @(negedge clk) begin
        e_rd = 1'b0; e_wr = 1'b0; e_own = 1'b0; e_stall = 1'b0;
        e_ack = 1'b0; e_err = 1'b0; e_addr = 32'h0; e_wdata = 32'h0;
        m_bad = guard_on && (bif.dma_addr >= 32'h0000_03ff);
        if (!reset) begin
            m_blocked = 0;
            m_force   = 1'b0;
        end else if (m_force) begin
            e_stall = 1'b1;
            if (bif.dma_req) begin
                e_ack = 1'b1; e_own = 1'b1; e_err = m_bad;
                e_rd = !m_bad && !bif.dma_wr; e_wr = !m_bad && bif.dma_wr;
                e_addr = bif.dma_addr; e_wdata = bif.dma_wdata;
            end
            m_force   = 1'b0;
            m_blocked = 0;
        end else if (bif.cpu_rd || bif.cpu_wr) begin
            e_rd = bif.cpu_rd; e_wr = bif.cpu_wr;
            e_addr = bif.cpu_addr; e_wdata = bif.cpu_wdata;
            if (bif.dma_req) begin
                m_blocked = m_blocked + 1;
                if (m_blocked >= MAX_WAIT) m_force = 1'b1;
            end else begin
                m_blocked = 0;
            end
        end else if (bif.dma_req) begin
            e_ack = 1'b1; e_own = 1'b1; e_err = m_bad;
            e_rd = !m_bad && !bif.dma_wr; e_wr = !m_bad && bif.dma_wr;
            e_addr = bif.dma_addr; e_wdata = bif.dma_wdata;
            m_blocked = 0;
        end else begin
            m_blocked = 0;
        end
        chk("mdl_bus_rd",    {63'h0, bif.bus_rd},    {63'h0, e_rd});
        chk("mdl_bus_wr",    {63'h0, bif.bus_wr},    {63'h0, e_wr});
        chk("mdl_bus_owner", {63'h0, bif.bus_owner}, {63'h0, e_own});
        chk("mdl_cpu_stall", {63'h0, bif.cpu_stall}, {63'h0, e_stall});
        chk("mdl_dma_ack",   {63'h0, bif.dma_ack},   {63'h0, e_ack});
        chk("mdl_dma_err",   {63'h0, bif.dma_err},   {63'h0, e_err});
        if (e_rd || e_wr) begin
            chk("mdl_bus_addr", {32'h0, bif.bus_addr}, {32'h0, e_addr});
        end
        if (e_wr) begin
            chk("mdl_bus_wdata", {32'h0, bif.bus_wdata}, {32'h0, e_wdata});
        end
        chk("mdl_cpu_rdata", {32'h0, bif.cpu_rdata}, {32'h0, bif.bus_rdata});
        chk("mdl_dma_rdata", {32'h0, bif.dma_rdata}, {32'h0, bif.bus_rdata});
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic rd, input logic wr);
        bif.cpu_rd = rd;
        bif.cpu_wr = wr;
    endtask

    task automatic set_dma(input logic req, input logic wr, input logic [31:0] addr);
        bif.dma_req  = req;
        bif.dma_wr   = wr;
        bif.dma_addr = addr;
    endtask

    bit ack_seen;

    initial begin
        vectors = 0; miscompares = 0;
        m_blocked = 0; m_force = 1'b0;
`ifdef ARB_ADDR_GUARD_EN
        guard_on = 1'b1;
`else
        guard_on = 1'b0;
`endif
        // 1: reset held with both requesters active.
        reset = 1'b0;
        bif.cpu_addr = 32'h0000_0100; bif.cpu_wdata = 32'hCAFE_0001;
        set_cpu(1'b0, 1'b1);
        set_dma(1'b1, 1'b1, 32'h0000_0020);
        bif.dma_wdata = 32'h1234_5678; bif.bus_rdata = 32'hA5A5_5A5A;
        #3;
        chk("rst_bus_wr",    {63'h0, bif.bus_wr},    64'h0);
        chk("rst_dma_ack",   {63'h0, bif.dma_ack},   64'h0);
        chk("rst_cpu_stall", {63'h0, bif.cpu_stall}, 64'h0);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        set_cpu(1'b0, 1'b0); set_dma(1'b0, 1'b0, 32'h0);

        // 2: CPU idle, DMA write to 0x10 granted in the same cycle.
        next_cycle();
        set_dma(1'b1, 1'b1, 32'h0000_0010);
        #2;
        chk("zl_bus_wr",    {63'h0, bif.bus_wr},    64'h1);
        chk("zl_bus_owner", {63'h0, bif.bus_owner}, 64'h1);
        chk("zl_dma_ack",   {63'h0, bif.dma_ack},   64'h1);
        chk("zl_bus_addr",  {32'h0, bif.bus_addr},  64'h10);

        // 3: CPU read held, DMA held: 4 CPU cycles, FORCE, CPU again.
        next_cycle();
        set_dma(1'b0, 1'b0, 32'h0);
        next_cycle();
        set_cpu(1'b1, 1'b0); set_dma(1'b1, 1'b0, 32'h0000_0040);
        for (int k = 0; k < 6; k++) begin
            #2;
            chk("st_owner", {63'h0, bif.bus_owner}, (k == 4) ? 64'h1 : 64'h0);
            chk("st_stall", {63'h0, bif.cpu_stall}, (k == 4) ? 64'h1 : 64'h0);
            chk("st_ack",   {63'h0, bif.dma_ack},   (k == 4) ? 64'h1 : 64'h0);
            next_cycle();
            if (k == 4) set_dma(1'b0, 1'b0, 32'h0);
        end

        // 4: 2 blocked, 1 dropped, reassert: forced slot 4 cycles after reassertion.
        set_dma(1'b1, 1'b0, 32'h0000_0044);
        next_cycle(); next_cycle();
        set_dma(1'b0, 1'b0, 32'h0000_0044);
        next_cycle();
        set_dma(1'b1, 1'b0, 32'h0000_0044);
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("gap_ack",   {63'h0, bif.dma_ack},   (k == 4) ? 64'h1 : 64'h0);
            chk("gap_stall", {63'h0, bif.cpu_stall}, (k == 4) ? 64'h1 : 64'h0);
            next_cycle();
        end
        set_dma(1'b0, 1'b0, 32'h0);
        next_cycle();

        // 5: reset pulsed in the FORCE cycle, then the wait restarts from zero.
        set_dma(1'b1, 1'b1, 32'h0000_0048);
        for (int k = 0; k < 4; k++) next_cycle();
        reset = 1'b0;
        #2;
        chk("rf_ack",   {63'h0, bif.dma_ack},   64'h0);
        chk("rf_bus_wr",{63'h0, bif.bus_wr},    64'h0);
        next_cycle();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("rf_restart_ack", {63'h0, bif.dma_ack}, (k == 4) ? 64'h1 : 64'h0);
            next_cycle();
        end
        set_cpu(1'b0, 1'b0); set_dma(1'b0, 1'b0, 32'h0);
        next_cycle();

        // 6: DMA read to a peripheral address with CPU idle.
        set_dma(1'b1, 1'b0, 32'h4000_000C);
        #2;
        chk("grd_ack", {63'h0, bif.dma_ack}, 64'h1);
`ifdef ARB_ADDR_GUARD_EN
        chk("grd_err",    {63'h0, bif.dma_err}, 64'h1);
        chk("grd_bus_rd", {63'h0, bif.bus_rd},  64'h0);
`else
        chk("grd_err",    {63'h0, bif.dma_err}, 64'h0);
        chk("grd_bus_rd", {63'h0, bif.bus_rd},  64'h1);
`endif
        next_cycle();
        set_dma(1'b0, 1'b0, 32'h0);

        // Randomised traffic checked by the model every cycle.
        ack_seen = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            next_cycle();
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            case ($urandom_range(0, 4))
                0: set_cpu(1'b0, 1'b0);
                1: set_cpu(1'b1, 1'b0);
                2: set_cpu(1'b0, 1'b1);
                3: set_cpu(1'b1, 1'b0);
                default: set_cpu(1'b0, 1'b0);
            endcase
            bif.cpu_addr  = $urandom;
            bif.cpu_wdata = $urandom;
            bif.bus_rdata = $urandom;
            if (!bif.dma_req || ack_seen) begin
                bif.dma_req   = ($urandom_range(0, 1) == 1);
                bif.dma_wr    = ($urandom_range(0, 1) == 1);
                bif.dma_wdata = $urandom;
                bif.dma_addr  = ($urandom_range(0, 3) == 0) ? $urandom
                                                            : 32'($urandom_range(0, 32'h0000_03fe));
            end else if ($urandom_range(0, 15) == 0) begin
                bif.dma_req = 1'b0;
            end
            @(negedge clk);
            ack_seen = bif.dma_ack;
        end
        next_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
